// File: rtl/qpu_exu_alu_dpath_arb.sv
// Two-requester arbiter in front of a shared combinational ALU datapath.
// Optional macro QPU_ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention.

`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

module qpu_exu_alu_dpath_arb #(
    parameter int XLEN = `QPU_XLEN,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i0_valid,
    output logic            i0_ready,
    input  logic [OPW-1:0]  i0_op,
    input  logic [XLEN-1:0] i0_op1,
    input  logic [XLEN-1:0] i0_op2,
    output logic            o0_valid,
    input  logic            o0_ready,
    output logic [XLEN-1:0] o0_res,

    input  logic            i1_valid,
    output logic            i1_ready,
    input  logic [OPW-1:0]  i1_op,
    input  logic [XLEN-1:0] i1_op1,
    input  logic [XLEN-1:0] i1_op2,
    output logic            o1_valid,
    input  logic            o1_ready,
    output logic [XLEN-1:0] o1_res,

    output logic            dp_add,
    output logic            dp_sub,
    output logic            dp_xor,
    output logic            dp_or,
    output logic            dp_and,
    output logic [XLEN-1:0] dp_op1,
    output logic [XLEN-1:0] dp_op2,
    input  logic [XLEN-1:0] dp_res,

    output logic            arb_err
);

    localparam logic [OPW-1:0] OP_ONE = OPW'(1);

    logic            buf_v0;
    logic            buf_v1;
    logic [XLEN-1:0] buf_d0;
    logic [XLEN-1:0] buf_d1;
    logic            rr;
    logic            err_q;

    logic            elig0;
    logic            elig1;
    logic            gnt0;
    logic            gnt1;
    logic            any_gnt;

    logic [OPW-1:0]  sel_op;
    logic [XLEN-1:0] sel_op1;
    logic [XLEN-1:0] sel_op2;
    logic            op_ok;
    logic [OPW-1:0]  dp_opv;
    logic [XLEN-1:0] wr_res;

    // A requester may issue when its buffer is free or draining this cycle
    always_comb begin
        elig0 = i0_valid & (~buf_v0 | o0_ready);
        elig1 = i1_valid & (~buf_v1 | o1_ready);
    end

    // Pick one eligible requester; nothing is granted while in reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
`ifdef QPU_ALU_ARB_FIXED_PRIO_EN
            gnt0 = elig0;
            gnt1 = elig1 & ~elig0;
`else
            if (elig0 & elig1) begin
                gnt0 = ~rr;
                gnt1 = rr;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
`endif
        end
        any_gnt = gnt0 | gnt1;
    end

    // Steer the granted request onto the shared datapath
    always_comb begin
        sel_op  = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        if (gnt0) begin
            sel_op  = i0_op;
            sel_op1 = i0_op1;
            sel_op2 = i0_op2;
        end else if (gnt1) begin
            sel_op  = i1_op;
            sel_op1 = i1_op1;
            sel_op2 = i1_op2;
        end
    end

    // Malformed ops (zero or several bits) are squashed to a zero result
    always_comb begin
        op_ok  = (sel_op != '0) && ((sel_op & (sel_op - OP_ONE)) == '0);
        dp_opv = op_ok ? sel_op : '0;
        wr_res = op_ok ? dp_res : '0;
    end

    // Datapath drive and handshake outputs
    always_comb begin
        dp_add   = dp_opv[0];
        dp_sub   = dp_opv[1];
        dp_xor   = dp_opv[2];
        dp_or    = dp_opv[3];
        dp_and   = dp_opv[4];
        dp_op1   = sel_op1;
        dp_op2   = sel_op2;
        i0_ready = gnt0;
        i1_ready = gnt1;
        o0_valid = buf_v0;
        o0_res   = buf_d0;
        o1_valid = buf_v1;
        o1_res   = buf_d1;
        arb_err  = err_q;
    end

    // Result buffer 0: refill wins over drain; data held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v0 <= 1'b0;
            buf_d0 <= '0;
        end else if (gnt0) begin
            buf_v0 <= 1'b1;
            buf_d0 <= wr_res;
        end else if (buf_v0 && o0_ready) begin
            buf_v0 <= 1'b0;
        end
    end

    // Result buffer 1: refill wins over drain; data held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v1 <= 1'b0;
            buf_d1 <= '0;
        end else if (gnt1) begin
            buf_v1 <= 1'b1;
            buf_d1 <= wr_res;
        end else if (buf_v1 && o1_ready) begin
            buf_v1 <= 1'b0;
        end
    end

    // Round-robin pointer hands priority to the requester not just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else begin
`ifdef QPU_ALU_ARB_FIXED_PRIO_EN
            rr <= 1'b0;
`else
            if (any_gnt) begin
                rr <= gnt0;
            end
`endif
        end
    end

    // Sticky error once a malformed op has been accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (any_gnt && !op_ok) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: doc/qpu_exu_alu_dpath_arb.md
QPU_EXU_ALU_DPATH_ARB -- requirements
Module: QPU_exu_alu_dpath_arb

Interface
REQ-001 SHALL have parameter XLEN, default `QPU_XLEN (32), operand/result width.
REQ-002 SHALL have parameter OPW, default 5, one-hot op vector width {and,or,xor,sub,add} (bit4..bit0).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i0_valid input 1 / i0_ready output 1: requester 0 (regular ALU) issue handshake.
REQ-006 SHALL have ports i0_op input OPW, i0_op1 input XLEN, i0_op2 input XLEN: requester 0 operation and operands.
REQ-007 SHALL have ports o0_valid output 1 / o0_ready input 1 / o0_res output XLEN: requester 0 result handshake.
REQ-008 SHALL have ports i1_valid, i1_ready, i1_op, i1_op1, i1_op2, o1_valid, o1_ready, o1_res, identical to REQ-005..007 for requester 1 (timing/branch unit).
REQ-009 SHALL have outputs dp_add, dp_sub, dp_xor, dp_or, dp_and (1 each), dp_op1, dp_op2 (XLEN): drive to shared datapath.
REQ-010 SHALL have input dp_res XLEN: combinational datapath result.
REQ-011 SHALL have output arb_err 1: sticky flag, accepted op not one-hot.

Function
REQ-012 SHALL keep one result buffer per requester (valid bit + XLEN data); o<n>_valid = buffer valid, o<n>_res = buffer data.
REQ-013 SHALL treat requester n eligible when i<n>_valid=1 and (buffer n empty, or o<n>_valid & o<n>_ready same cycle).
REQ-014 SHALL grant at most one eligible requester per cycle; i<n>_ready=1 only for the granted requester, 0 otherwise.
REQ-015 SHALL arbitrate round-robin: 1-bit pointer rr names the high-priority requester; on a grant to n, rr <= ~n; with no grant, rr holds.
REQ-016 SHALL drive dp_* from the granted requester's op/operands; with no grant, all dp op bits 0 and dp_op1/dp_op2 = 0.
REQ-017 SHALL capture dp_res into buffer n on the grant edge; latency issue->o<n>_valid exactly 1 cycle.
REQ-018 SHALL clear buffer n valid on o<n>_valid & o<n>_ready unless refilled the same edge (refill wins, valid stays 1).
REQ-019 SHALL hold buffer data stable while o<n>_valid=1 and o<n>_ready=0.
REQ-020 SHALL, if the granted op has zero or >1 bits set, issue all dp op bits 0, store result 0, set arb_err (cleared only by reset).
REQ-021 SHALL produce no combinational path from o<n>_ready to o<n>_valid/o<n>_res; i<n>_ready may depend combinationally on o<n>_ready.

Reset
REQ-022 SHALL on rst_n=0 asynchronously clear both buffer valids and data to 0, rr to 0, arb_err to 0.
REQ-023 SHALL drop any in-flight result when reset asserts mid-operation; after release, first grant follows rr=0.
REQ-024 SHALL drive i0_ready=i1_ready=0 and all dp op bits 0 while rst_n=0.

Configuration
REQ-025 SHALL with macro QPU_ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention, rr unused (held at 0).
REQ-026 SHALL with QPU_ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015.

Verification
REQ-027 SHALL cover: single issue, i0 add op1=5 op2=7, o0_ready=1 -> i0_ready=1 cycle 0, o0_valid=1 o0_res=12 cycle 1, o0_valid=0 cycle 2.
REQ-028 SHALL cover: both valid every cycle, both o_ready=1, after reset -> grants 0,1,0,1 on successive cycles (fixed-prio build: 0,0,0,0).
REQ-029 SHALL cover: o0_ready=0 with o0 buffer full -> i0_ready=0, i1 (sub 9-4) granted, o1_res=5; o0_res unchanged for 4 stalled cycles.
REQ-030 SHALL cover: back-to-back i0 xor 0xF0^0xFF then or 0x1|0x2 with o0_ready=1 -> o0_valid continuous, results 0x0F then 0x3.
REQ-031 SHALL cover: i1_op=5'b00011 -> o1_res=0, dp op bits 0 that cycle, arb_err=1 thereafter until reset.
REQ-032 SHALL cover: rst_n low while o0_valid=1 -> o0_valid=0 immediately (asynchronous), o0_res=0, rr=0.
